chip_readout_sequencer: RTL and testbench

Parametrised successor to the single-chip readout controller. It sequences readout of up to NUM_CH chips sharing one AD9228 FIFO path, one channel after another. It has a per-channel sample count, FIFO back-pressure stall, a configurable ADC pipeline latency, abort, and per-channel trigger counters. It sits between the register block (start/config) and the clock-gating buffers and FIFO write port. It emits clock enables rather than gated clocks.

---
 rtl/read_seq_pkg.sv | 19 +
 rtl/trig_edge_counter.sv | 40 ++++
 rtl/chip_readout_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_chip_readout_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_seq_pkg.sv
// Shared types and width helpers for the chip readout sequencer.
package read_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        NEXT  = 2'd3
    } seq_state_e;

    function automatic int cnt_w(input int max_samples);
        return $clog2(max_samples + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trig_edge_counter.sv
// Per-chip trigger counter: 2-flop synchroniser, rising-edge detect, wrapping count with clear.
module trig_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             trig_i,
    input  logic             clr_i,
    output logic             edge_o,
    output logic [CNT_W-1:0] count_o
);

    // sync_q[1:0] is the synchroniser, sync_q[2] holds the previous synchronised level
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign edge_o  = sync_q[1] & ~sync_q[2];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (edge_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            count_q <= '0;
        end else begin
            sync_q  <= {sync_q[1:0], trig_i};
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/chip_readout_sequencer.sv
// Sequences clock-enabled readout of up to NUM_CH chips into one FIFO, with stall, abort and trigger counters.
// Optional READOUT_AUTO_TRIG_EN adds auto_mode: a masked trigger edge starts a sequence while idle.
module chip_readout_sequencer
    import read_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int MAX_SAMPLES = 1280,
    parameter int ADC_LAT     = 2,
    parameter int TRIG_CNT_W  = 16,
    localparam int CNT_W      = cnt_w(MAX_SAMPLES),
    localparam int CH_W       = idx_w(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            trig_from_chip,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [CNT_W-1:0]             num_samples,
    input  logic                         trig_cnt_clr,
    input  logic                         fifo_afull,
`ifdef READOUT_AUTO_TRIG_EN
    input  logic                         auto_mode,
`endif
    output logic [NUM_CH-1:0]            read_clk_en,
    output logic                         adc_wr_en,
    output logic [CH_W-1:0]              adc_ch,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic [NUM_CH*TRIG_CNT_W-1:0] trigger_counter
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_SAMPLES);

    seq_state_e        state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  nsamp_q, nsamp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [3:0]        flush_q, flush_d;
    logic              afull_q;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              pipe_clr;
    logic              en_active;
    logic              seq_start;
    logic              nxt_found;
    logic [CH_W-1:0]   nxt_ch;
    logic [NUM_CH-1:0] nxt_onehot;
    logic [NUM_CH-1:0] trig_edge;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_trig
            trig_edge_counter #(
                .CNT_W(TRIG_CNT_W)
            ) u_trig (
                .clk_i   (clk),
                .rst_i   (rst),
                .trig_i  (trig_from_chip[g]),
                .clr_i   (trig_cnt_clr),
                .edge_o  (trig_edge[g]),
                .count_o (trigger_counter[g*TRIG_CNT_W +: TRIG_CNT_W])
            );
        end
    endgenerate

`ifdef READOUT_AUTO_TRIG_EN
    assign seq_start = start | (auto_mode & (|(trig_edge & ch_mask)));
`else
    assign seq_start = start;
    // Edge pulses only feed auto-start; keep them referenced in this build
    logic unused_trig_edge;
    assign unused_trig_edge = ^trig_edge;
`endif

    assign en_active = (state_q == READ) && !afull_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign aborted   = aborted_q;

    always_comb begin
        read_clk_en = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            read_clk_en[i] = en_active && (ch_q == CH_W'(i));
        end
    end

    always_comb begin
        nxt_found  = 1'b0;
        nxt_ch     = '0;
        nxt_onehot = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (mask_q[i] && !nxt_found) begin
                nxt_found     = 1'b1;
                nxt_ch        = CH_W'(i);
                nxt_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        nsamp_d   = nsamp_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        flush_d   = flush_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        pipe_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (seq_start && !abort) begin
                    // An out-of-range count skips every channel: pending mask starts empty
                    mask_d  = (num_samples == '0 || num_samples > MAX_N) ? '0 : ch_mask;
                    nsamp_d = num_samples;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (nxt_found) begin
                    ch_d    = nxt_ch;
                    mask_d  = mask_q & ~nxt_onehot;
                    cnt_d   = '0;
                    state_d = READ;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            READ: begin
                if (en_active) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == nsamp_q) begin
                        flush_d = '0;
                        state_d = (ADC_LAT == 0) ? NEXT : FLUSH;
                    end
                end
            end
            FLUSH: begin
                flush_d = flush_q + 1'b1;
                if (flush_q == 4'(ADC_LAT - 1)) begin
                    state_d = NEXT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            mask_d    = '0;
            aborted_d = 1'b1;
            pipe_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            nsamp_q   <= '0;
            cnt_q     <= '0;
            ch_q      <= '0;
            flush_q   <= '0;
            afull_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            nsamp_q   <= nsamp_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            flush_q   <= flush_d;
            afull_q   <= fifo_afull;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    generate
        if (ADC_LAT == 0) begin : g_no_lat
            assign adc_wr_en = en_active;
            assign adc_ch    = ch_q;
        end else begin : g_lat
            logic            wr_pipe_q [ADC_LAT];
            logic [CH_W-1:0] ch_pipe_q [ADC_LAT];

            always_ff @(posedge clk) begin
                if (rst || pipe_clr) begin
                    for (int unsigned i = 0; i < ADC_LAT; i++) begin
                        wr_pipe_q[i] <= 1'b0;
                        ch_pipe_q[i] <= '0;
                    end
                end else begin
                    wr_pipe_q[0] <= en_active;
                    ch_pipe_q[0] <= ch_q;
                    for (int unsigned i = 1; i < ADC_LAT; i++) begin
                        wr_pipe_q[i] <= wr_pipe_q[i-1];
                        ch_pipe_q[i] <= ch_pipe_q[i-1];
                    end
                end
            end

            assign adc_wr_en = wr_pipe_q[ADC_LAT-1];
            assign adc_ch    = ch_pipe_q[ADC_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_chip_readout_sequencer.sv
// Self-checking bench for chip_readout_sequencer: scoreboard of FIFO writes plus per-scenario timing checks.
module tb_chip_readout_sequencer;

    localparam int NUM_CH      = 4;
    localparam int MAX_SAMPLES = 1280;
    localparam int ADC_LAT     = 2;
    localparam int TRIG_CNT_W  = 8;
    localparam int CNT_W       = 11;

    logic                         clk;
    logic                         rst;
    logic [NUM_CH-1:0]            trig_from_chip;
    logic                         start;
    logic                         abort;
    logic [NUM_CH-1:0]            ch_mask;
    logic [CNT_W-1:0]             num_samples;
    logic                         trig_cnt_clr;
    logic                         fifo_afull;
    logic [NUM_CH-1:0]            read_clk_en;
    logic                         adc_wr_en;
    logic [1:0]                   adc_ch;
    logic                         busy;
    logic                         done;
    logic                         aborted;
    logic [NUM_CH*TRIG_CNT_W-1:0] trigger_counter;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int q_exp[$];
    int done_cnt, aborted_cnt, done_cyc, first_en_cyc;
    int en_cnt[NUM_CH];

    chip_readout_sequencer #(
        .NUM_CH      (NUM_CH),
        .MAX_SAMPLES (MAX_SAMPLES),
        .ADC_LAT     (ADC_LAT),
        .TRIG_CNT_W  (TRIG_CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .trig_from_chip  (trig_from_chip),
        .start           (start),
        .abort           (abort),
        .ch_mask         (ch_mask),
        .num_samples     (num_samples),
        .trig_cnt_clr    (trig_cnt_clr),
        .fifo_afull      (fifo_afull),
`ifdef READOUT_AUTO_TRIG_EN
        .auto_mode       (1'b0),
`endif
        .read_clk_en     (read_clk_en),
        .adc_wr_en       (adc_wr_en),
        .adc_ch          (adc_ch),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .trigger_counter (trigger_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pop on every write, event statistics, one-hot enable
    always @(negedge clk) begin
        int exp_ch;
        if (!rst) begin
            checks++;
            if ($countones(read_clk_en) > 1) begin
                errors++;
                $display("FAIL onehot_en cyc=%0d read_clk_en=%b required at most one bit", cyc, read_clk_en);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (read_clk_en[i]) begin
                    en_cnt[i]++;
                    if (first_en_cyc < 0) first_en_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (aborted) aborted_cnt++;
            if (adc_wr_en) begin
                checks++;
                if (q_exp.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected cyc=%0d adc_ch=%0d required no write", cyc, adc_ch);
                end else begin
                    exp_ch = q_exp.pop_front();
                    if (int'(adc_ch) !== exp_ch) begin
                        errors++;
                        $display("FAIL wr_tag cyc=%0d adc_ch=%0d required %0d", cyc, adc_ch, exp_ch);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        done_cnt     = 0;
        aborted_cnt  = 0;
        done_cyc     = -1;
        first_en_cyc = -1;
        for (int i = 0; i < NUM_CH; i++) en_cnt[i] = 0;
    endtask

    task automatic push_exp(input int ch, input int n);
        for (int i = 0; i < n; i++) q_exp.push_back(ch);
    endtask

    task automatic do_start(input logic [NUM_CH-1:0] m, input int n, output int t);
        ch_mask     = m;
        num_samples = CNT_W'(n);
        start       = 1'b1;
        t           = cyc;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt + aborted_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (read_clk_en !== '0) begin errors++; $display("FAIL rst_en got=%b required 0", read_clk_en); end
        checks++; if (adc_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr got=%b required 0", adc_wr_en); end
        checks++; if (adc_ch !== 2'd0) begin errors++; $display("FAIL rst_ch got=%0d required 0", adc_ch); end
        checks++; if ({busy, done, aborted} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b required 000", {busy, done, aborted}); end
        checks++; if (trigger_counter !== '0) begin errors++; $display("FAIL rst_trig got=%h required 0", trigger_counter); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int t;
        bit ok;
        clear_stats();
        push_exp(0, 8);
        push_exp(2, 8);
        do_start(4'b0101, 8, t);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b required 1", busy); end
        wait_end(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=no end required done"); end
        checks++; if (first_en_cyc != t + 2) begin errors++; $display("FAIL basic_first_en got=%0d required %0d", first_en_cyc, t + 2); end
        checks++; if (done_cyc != t + 24) begin errors++; $display("FAIL basic_done_cyc got=%0d required %0d", done_cyc, t + 24); end
        checks++; if (en_cnt[0] != 8 || en_cnt[2] != 8 || en_cnt[1] + en_cnt[3] != 0) begin
            errors++; $display("FAIL basic_en_cnt got=%0d,%0d,%0d,%0d required 8,0,8,0", en_cnt[0], en_cnt[1], en_cnt[2], en_cnt[3]);
        end
        checks++; if (q_exp.size() != 0) begin errors++; $display("FAIL basic_writes_missing got=%0d left required 0", q_exp.size()); end
        checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_once got=%0d busy=%b required 1 busy=0", done_cnt, busy); end
    endtask

    task automatic test_stall();
        int t;
        bit ok;
        clear_stats();
        push_exp(1, 10);
        do_start(4'b0010, 10, t);
        repeat (3) tick();
        fifo_afull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 4) fifo_afull = 1'b0;
            @(negedge clk);
            checks++;
            if (read_clk_en !== '0) begin errors++; $display("FAIL stall_pause cyc=%0d got=%b required 0000", cyc, read_clk_en); end
        end
        tick();
        @(negedge clk);
        checks++; if (read_clk_en !== 4'b0010) begin errors++; $display("FAIL stall_resume got=%b required 0010", read_clk_en); end
        wait_end(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=no end required done"); end
        checks++; if (done_cyc != t + 20) begin errors++; $display("FAIL stall_done_cyc got=%0d required %0d", done_cyc, t + 20); end
        checks++; if (en_cnt[1] != 10) begin errors++; $display("FAIL stall_en_cnt got=%0d required 10", en_cnt[1]); end
        checks++; if (q_exp.size() != 0) begin errors++; $display("FAIL stall_writes_missing got=%0d left required 0", q_exp.size()); end
    endtask

    task automatic test_abort();
        int t;
        clear_stats();
        push_exp(0, 20);
        push_exp(1, 4);
        do_start(4'b1111, 20, t);
        while (cyc < t + 30) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        checks++; if (read_clk_en !== '0) begin errors++; $display("FAIL abort_en got=%b required 0000", read_clk_en); end
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_pulse got=%b required 1", aborted); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b required 0", busy); end
        repeat (10) tick();
        checks++; if (aborted_cnt != 1 || done_cnt != 0) begin errors++; $display("FAIL abort_events got=aborted %0d done %0d required 1 0", aborted_cnt, done_cnt); end
        checks++; if (en_cnt[1] != 6 || en_cnt[2] + en_cnt[3] != 0) begin errors++; $display("FAIL abort_en_cnt got=%0d,%0d required 6,0", en_cnt[1], en_cnt[2] + en_cnt[3]); end
        checks++; if (q_exp.size() != 0) begin errors++; $display("FAIL abort_writes_missing got=%0d left required 0", q_exp.size()); end
    endtask

    task automatic test_empty();
        logic [NUM_CH-1:0] masks[3] = '{4'b0000, 4'b1111, 4'b1111};
        int nums[3] = '{8, 0, MAX_SAMPLES + 1};
        int t;
        bit ok;
        for (int c = 0; c < 3; c++) begin
            clear_stats();
            do_start(masks[c], nums[c], t);
            wait_end(20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL empty%0d_timeout got=no end required done", c); end
            checks++; if (done_cyc != t + 2) begin errors++; $display("FAIL empty%0d_done_cyc got=%0d required %0d", c, done_cyc, t + 2); end
            checks++; if (first_en_cyc != -1) begin errors++; $display("FAIL empty%0d_en got=first at %0d required none", c, first_en_cyc); end
        end
    endtask

    task automatic test_busy_start();
        int t;
        bit ok;
        clear_stats();
        push_exp(0, 5);
        do_start(4'b0001, 5, t);
        repeat (3) tick();
        ch_mask     = 4'b1000;
        num_samples = CNT_W'(3);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        wait_end(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_start_timeout got=no end required done"); end
        checks++; if (done_cyc != t + 10) begin errors++; $display("FAIL busy_start_done got=%0d required %0d", done_cyc, t + 10); end
        checks++; if (en_cnt[0] != 5 || en_cnt[3] != 0) begin errors++; $display("FAIL busy_start_en got=%0d,%0d required 5,0", en_cnt[0], en_cnt[3]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || q_exp.size() != 0) begin errors++; $display("FAIL busy_start_idle got=busy %b left %0d required 0 0", busy, q_exp.size()); end
    endtask

    task automatic test_abort_start_idle();
        clear_stats();
        ch_mask     = 4'b0001;
        num_samples = CNT_W'(4);
        start       = 1'b1;
        abort       = 1'b1;
        tick();
        start       = 1'b0;
        abort       = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy got=%b required 0", busy); end
        repeat (5) tick();
        checks++; if (done_cnt + aborted_cnt != 0 || first_en_cyc != -1) begin
            errors++; $display("FAIL abort_start_events got=done %0d aborted %0d en %0d required none", done_cnt, aborted_cnt, first_en_cyc);
        end
    endtask

    task automatic test_trig();
        logic [TRIG_CNT_W-1:0] c0, c1, c2, c3;
        trig_from_chip[1] = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        c1 = trigger_counter[1*TRIG_CNT_W +: TRIG_CNT_W];
        checks++; if (c1 !== 8'd0) begin errors++; $display("FAIL trig_latency_early got=%0d required 0", c1); end
        tick();
        @(negedge clk);
        c1 = trigger_counter[1*TRIG_CNT_W +: TRIG_CNT_W];
        checks++; if (c1 !== 8'd1) begin errors++; $display("FAIL trig_latency got=%0d required 1", c1); end
        trig_from_chip[1] = 1'b0;
        for (int k = 0; k < 600; k++) begin
            trig_from_chip[3] = 1'b1;
            repeat (2) tick();
            trig_from_chip[3] = 1'b0;
            repeat (2) tick();
        end
        repeat (4) tick();
        c0 = trigger_counter[0*TRIG_CNT_W +: TRIG_CNT_W];
        c1 = trigger_counter[1*TRIG_CNT_W +: TRIG_CNT_W];
        c2 = trigger_counter[2*TRIG_CNT_W +: TRIG_CNT_W];
        c3 = trigger_counter[3*TRIG_CNT_W +: TRIG_CNT_W];
        checks++; if (c3 !== 8'(600 % 256)) begin errors++; $display("FAIL trig_wrap got=%0d required %0d", c3, 600 % 256); end
        checks++; if ({c0, c1, c2} !== {8'd0, 8'd1, 8'd0}) begin errors++; $display("FAIL trig_indep got=%0d,%0d,%0d required 0,1,0", c0, c1, c2); end
        trig_from_chip[0] = 1'b1;
        repeat (2) tick();
        trig_cnt_clr = 1'b1;
        tick();
        trig_cnt_clr = 1'b0;
        repeat (3) tick();
        checks++; if (trigger_counter !== '0) begin errors++; $display("FAIL trig_clr_wins got=%h required 0", trigger_counter); end
        trig_from_chip[0] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_rst_mid();
        int t;
        clear_stats();
        push_exp(2, 30);
        trig_from_chip[2] = 1'b1;
        do_start(4'b0100, 30, t);
        repeat (10) tick();
        checks++; if (trigger_counter[2*TRIG_CNT_W +: TRIG_CNT_W] !== 8'd1) begin
            errors++; $display("FAIL rst_mid_trig_pre got=%0d required 1", trigger_counter[2*TRIG_CNT_W +: TRIG_CNT_W]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q_exp.delete();
        @(negedge clk);
        checks++; if (read_clk_en !== '0 || adc_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_en got=%b wr=%b required 0", read_clk_en, adc_wr_en); end
        checks++; if ({busy, done, aborted} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got=%b required 000", {busy, done, aborted}); end
        checks++; if (trigger_counter !== '0) begin errors++; $display("FAIL rst_mid_trig got=%h required 0", trigger_counter); end
        trig_from_chip[2] = 1'b0;
        repeat (5) tick();
        checks++; if (busy !== 1'b0 || done_cnt != 0) begin errors++; $display("FAIL rst_mid_idle got=busy %b done %0d required 0 0", busy, done_cnt); end
    endtask

    initial begin
        rst            = 1'b1;
        trig_from_chip = '0;
        start          = 1'b0;
        abort          = 1'b0;
        ch_mask        = '0;
        num_samples    = '0;
        trig_cnt_clr   = 1'b0;
        fifo_afull     = 1'b0;
        clear_stats();

        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_empty();
        test_busy_start();
        test_abort_start_idle();
        test_trig();
        test_rst_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
